// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the shared-memory multicycle MIPS datapath, with a bounded
// memory wait-state timeout. Define MC_ILLEGAL_TRAP_EN to halt on undecodable instructions.
module multicycle_control_unit #(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] operation,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       mem_we,
  output logic       reg_we,
  output logic       i_or_d,
  output logic       reg_write_addr,
  output logic       reg_write_data,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zero_ext,
  output logic [2:0] alu_controller,
  output logic [1:0] pc_src,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_IMM_EXEC  = 4'd9,
    S_IMM_WB    = 4'd10,
    S_JUMP      = 4'd11,
    S_JR        = 4'd12,
    S_HALT      = 4'd13
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // A zero-width counter is not legal, so MAX_WAIT=0 keeps a 1-bit free-running one.
  localparam int         CW   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] WLIM = CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  state_t        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          bus_err_q, bus_err_d;
  logic          pc_we_s, ir_we_s, mem_we_s, reg_we_s;
  logic          wait_st, bad;
  logic          r_ok, r_shamt;
  logic [2:0]    r_alu;

  // R-type function decode: ALU code, legality and whether shamt feeds port A.
  always_comb begin
    r_ok    = 1'b1;
    r_shamt = 1'b0;
    r_alu   = ALU_ADD;
    case (func)
      6'b000000: begin r_alu = ALU_SLL; r_shamt = 1'b1; end
      6'b000010: begin r_alu = ALU_SRL; r_shamt = 1'b1; end
      6'b000011: begin r_alu = ALU_SRA; r_shamt = 1'b1; end
      6'b000100: r_alu = ALU_SLL;
      6'b000110: r_alu = ALU_SRL;
      6'b000111: r_alu = ALU_SRA;
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b101010: r_alu = ALU_SLT;
      default:   r_ok  = 1'b0;
    endcase
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  always_comb begin
    state_d        = state_q;
    wcnt_d         = wcnt_q;
    bus_err_d      = bus_err_q;
`ifdef MC_ILLEGAL_TRAP_EN
    illegal_d      = illegal_q;
`endif
    bad            = 1'b0;
    pc_we_s        = 1'b0;
    ir_we_s        = 1'b0;
    mem_we_s       = 1'b0;
    reg_we_s       = 1'b0;
    i_or_d         = 1'b0;
    reg_write_addr = 1'b0;
    reg_write_data = 1'b0;
    alu_src_a      = 2'b00;
    alu_src_b      = 2'b00;
    imm_zero_ext   = 1'b0;
    alu_controller = 3'b000;
    pc_src         = 2'b00;
    wait_st        = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                     (state_q == S_MEM_WRITE);

    case (state_q)
      S_FETCH: begin
        alu_src_b      = 2'b01;
        alu_controller = ALU_ADD;
        if (mem_ready) begin
          pc_we_s = 1'b1;
          ir_we_s = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b      = 2'b11;
        alu_controller = ALU_ADD;
        case (operation)
          OP_LW, OP_SW:           state_d = S_MEM_ADDR;
          OP_RTYPE: begin
            if (func == FN_JR)    state_d = S_JR;
            else if (r_ok)        state_d = S_EXECUTE;
            else                  bad     = 1'b1;
          end
          OP_BEQ, OP_BNE:         state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMM_EXEC;
          OP_J:                   state_d = S_JUMP;
          default:                bad     = 1'b1;
        endcase
        if (bad) begin
`ifdef MC_ILLEGAL_TRAP_EN
          state_d   = S_HALT;
          illegal_d = 1'b1;
`else
          state_d   = S_FETCH;
`endif
        end
      end
      S_MEM_ADDR: begin
        alu_src_a      = 2'b01;
        alu_src_b      = 2'b10;
        alu_controller = ALU_ADD;
        state_d        = (operation == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        i_or_d = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_we_s       = 1'b1;
        reg_write_data = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEM_WRITE: begin
        i_or_d   = 1'b1;
        mem_we_s = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a      = r_shamt ? 2'b10 : 2'b01;
        alu_controller = r_alu;
        state_d        = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_we_s       = 1'b1;
        reg_write_addr = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a      = 2'b01;
        alu_controller = ALU_SUB;
        pc_src         = 2'b01;
        pc_we_s        = (operation == OP_BEQ) ? zero : !zero;
        state_d        = S_FETCH;
      end
      S_IMM_EXEC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        case (operation)
          OP_ANDI: begin alu_controller = ALU_AND; imm_zero_ext = 1'b1; end
          OP_ORI:  begin alu_controller = ALU_OR;  imm_zero_ext = 1'b1; end
          default: alu_controller = ALU_ADD;
        endcase
        state_d = S_IMM_WB;
      end
      S_IMM_WB: begin
        reg_we_s = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_we_s = 1'b1;
        state_d = S_FETCH;
      end
      S_JR: begin
        pc_src  = 2'b11;
        pc_we_s = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // A ready on the final allowed cycle still completes the access normally.
    if ((MAX_WAIT > 0) && wait_st && !mem_ready && (wcnt_q == WLIM)) begin
      state_d   = S_HALT;
      bus_err_d = 1'b1;
    end

    if (state_d != state_q)          wcnt_d = '0;
    else if (wait_st && !mem_ready)  wcnt_d = wcnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wcnt_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      bus_err_q <= bus_err_d;
    end
  end

`ifdef MC_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Reset is asynchronous, so enables are also masked combinationally while it is held.
  assign pc_we   = pc_we_s  & ~rst;
  assign ir_we   = ir_we_s  & ~rst;
  assign mem_we  = mem_we_s & ~rst;
  assign reg_we  = reg_we_s & ~rst;
  assign bus_err = bus_err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized check of multicycle_control_unit against an instruction-level model that
// expands each instruction into its expected per-cycle state and output sequence.
module tb_multicycle_control_unit;
  localparam int MW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] operation, func;
  logic       zero, mem_ready;
  logic       pc_we, ir_we, mem_we, reg_we, i_or_d, reg_write_addr, reg_write_data;
  logic [1:0] alu_src_a, alu_src_b, pc_src;
  logic       imm_zero_ext, illegal, bus_err;
  logic [2:0] alu_controller;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control_unit #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .operation(operation), .func(func), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .mem_we(mem_we),
    .reg_we(reg_we), .i_or_d(i_or_d), .reg_write_addr(reg_write_addr),
    .reg_write_data(reg_write_data), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_zero_ext(imm_zero_ext), .alu_controller(alu_controller), .pc_src(pc_src),
    .illegal(illegal), .bus_err(bus_err), .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
    logic [1:0] fl;   // {illegal, bus_err}
  } step_t;

  step_t      seq[$];
  logic [1:0] xf = 2'b00;
  int         n_chk = 0, n_pass = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc%0d: got %h expected %h", tag, cyc, got, exp);
  endtask

  function automatic bit rfn_ok(input logic [5:0] fn);
    return fn inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
  endfunction

  // Expected output vector for one cycle, straight from the per-state output table.
  function automatic logic [16:0] exp_out(input logic [3:0] s, input logic [5:0] op,
                                          input logic [5:0] fn, input logic z, input logic mr);
    logic pw, iw, mwe, rw, iod, rwa, rwd, ze;
    logic [1:0] sa, sb, ps;
    logic [2:0] alu;
    {pw, iw, mwe, rw, iod, rwa, rwd, ze} = '0;
    sa = 0; sb = 0; ps = 0; alu = 0;
    case (s)
      0:  begin sb = 2'b01; alu = 3'b010; pw = mr; iw = mr; end
      1:  begin sb = 2'b11; alu = 3'b010; end
      2:  begin sa = 2'b01; sb = 2'b10; alu = 3'b010; end
      3:  iod = 1;
      4:  begin rw = 1; rwd = 1; end
      5:  begin iod = 1; mwe = 1; end
      6:  begin
        sa = (fn inside {6'd0, 6'd2, 6'd3}) ? 2'b10 : 2'b01;
        case (fn)
          6'd0, 6'd4: alu = 3'b011;
          6'd2, 6'd6: alu = 3'b100;
          6'd3, 6'd7: alu = 3'b101;
          6'd32:      alu = 3'b010;
          6'd34:      alu = 3'b110;
          6'd36:      alu = 3'b000;
          6'd37:      alu = 3'b001;
          default:    alu = 3'b111;
        endcase
      end
      7:  begin rw = 1; rwa = 1; end
      8:  begin sa = 2'b01; alu = 3'b110; ps = 2'b01; pw = (op == 6'b000100) ? z : !z; end
      9:  begin
        sa = 2'b01; sb = 2'b10;
        if (op == 6'b001100)      begin alu = 3'b000; ze = 1; end
        else if (op == 6'b001101) begin alu = 3'b001; ze = 1; end
        else                      alu = 3'b010;
      end
      10: rw = 1;
      11: begin ps = 2'b10; pw = 1; end
      12: begin ps = 2'b11; pw = 1; end
      default: ;
    endcase
    return {pw, iw, mwe, rw, iod, rwa, rwd, sa, sb, ze, alu, ps};
  endfunction

  task automatic push_wait(input logic [3:0] s, input int k);
    for (int i = 0; i < k; i++) seq.push_back('{s, 1'b0, xf});
    seq.push_back('{s, 1'b1, xf});
  endtask

  task automatic push_st(input logic [3:0] s);
    seq.push_back('{s, 1'($urandom_range(0, 1)), xf});
  endtask

  // Expand one instruction into its state sequence; kf/km are low-ready cycles before completion.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int kf, input int km);
    seq.delete();
    push_wait(0, kf);
    push_st(1);
    case (op)
      6'b100011: begin push_st(2); push_wait(3, km); push_st(4); end
      6'b101011: begin push_st(2); push_wait(5, km); end
      6'b000000: begin
        if (fn == 6'b001000)  push_st(12);
        else if (rfn_ok(fn)) begin push_st(6); push_st(7); end
      end
      6'b000100, 6'b000101: push_st(8);
      6'b001000, 6'b001100, 6'b001101: begin push_st(9); push_st(10); end
      6'b000010: push_st(11);
      default: ;
    endcase
  endtask

  task automatic play(input logic [5:0] op, input logic [5:0] fn, input logic z, input int n);
    for (int i = 0; i < n && i < seq.size(); i++) begin
      operation = op; func = fn; zero = z; mem_ready = seq[i].mr;
      #2;
      chk("state", 32'(state), 32'(seq[i].st));
      chk("outs", 32'({pc_we, ir_we, mem_we, reg_we, i_or_d, reg_write_addr, reg_write_data,
                       alu_src_a, alu_src_b, imm_zero_ext, alu_controller, pc_src}),
          32'(exp_out(seq[i].st, op, fn, z, seq[i].mr)));
      chk("flags", 32'({illegal, bus_err}), 32'(seq[i].fl));
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic reset_check();
    mem_ready = 1'b1;
    rst = 1'b1;
    xf = 2'b00;
    for (int r = 0; r < 2; r++) begin
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_outs", 32'({pc_we, ir_we, mem_we, reg_we, i_or_d, reg_write_addr, reg_write_data,
                           alu_src_a, alu_src_b, imm_zero_ext, alu_controller, pc_src}),
          32'(exp_out(4'd0, operation, func, zero, 1'b0)));
      chk("rst_flags", 32'({illegal, bus_err}), 32'd0);
      @(posedge clk); #1; cyc++;
    end
    rst = 1'b0;
  endtask

  logic [5:0] ops[10] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                          6'b001000, 6'b001100, 6'b001101, 6'b000010, 6'b111111};
  logic [5:0] rfns[12] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd32, 6'd34, 6'd36,
                           6'd37, 6'd42, 6'd8};

  initial begin
    rst = 1'b1; operation = 0; func = 0; zero = 0; mem_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_check();

    build(6'b100011, 6'd0, 0, 0);  play(6'b100011, 6'd0, 1'b0, seq.size());   // lw
    build(6'b000100, 6'd0, 0, 0);  play(6'b000100, 6'd0, 1'b1, seq.size());   // beq taken
    build(6'b000100, 6'd0, 0, 0);  play(6'b000100, 6'd0, 1'b0, seq.size());   // beq not taken
    build(6'b000101, 6'd0, 0, 0);  play(6'b000101, 6'd0, 1'b0, seq.size());   // bne taken
    build(6'b101011, 6'd0, 1, 3);  play(6'b101011, 6'd0, 1'b0, seq.size());   // sw, 3 waits
    build(6'b000000, 6'd0, 3, 0);  play(6'b000000, 6'd0, 1'b0, seq.size());   // sll, fetch at limit
    build(6'b000000, 6'd8, 0, 0);  play(6'b000000, 6'd8, 1'b0, seq.size());   // jr
`ifndef MC_ILLEGAL_TRAP_EN
    build(6'b111111, 6'd0, 0, 0);  play(6'b111111, 6'd0, 1'b0, seq.size());   // NOP
    build(6'b000000, 6'h3f, 0, 0); play(6'b000000, 6'h3f, 1'b0, seq.size());
`endif

    // Random instruction stream
    for (int n = 0; n < 200; n++) begin
      logic [5:0] op, fn;
      logic z;
`ifdef MC_ILLEGAL_TRAP_EN
      op = ops[$urandom_range(0, 8)];
      fn = rfns[$urandom_range(0, 11)];
`else
      op = ops[$urandom_range(0, 9)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : rfns[$urandom_range(0, 11)];
`endif
      z = 1'($urandom);
      build(op, fn, $urandom_range(0, MW - 1), $urandom_range(0, MW - 1));
      play(op, fn, z, seq.size());
      if (n == 100) begin
        build(6'b100011, 6'd0, 0, 0);
        play(6'b100011, 6'd0, 1'b0, 3);   // abandon lw in MEM_READ
        reset_check();
      end
    end

    // Ready stuck low in FETCH: timeout into HALT, enables stay off
    seq.delete();
    for (int i = 0; i < MW; i++) seq.push_back('{4'd0, 1'b0, xf});
    xf = 2'b01;
    for (int i = 0; i < 4; i++) push_st(13);
    play(6'b100011, 6'd0, 1'b0, seq.size());
    reset_check();

    // Ready stuck low in MEM_READ
    build(6'b100011, 6'd0, 0, 0);
    void'(seq.pop_back()); void'(seq.pop_back());
    for (int i = 0; i < MW; i++) seq.push_back('{4'd3, 1'b0, xf});
    xf = 2'b01;
    for (int i = 0; i < 3; i++) push_st(13);
    play(6'b100011, 6'd0, 1'b0, seq.size());
    reset_check();

`ifdef MC_ILLEGAL_TRAP_EN
    build(6'b111111, 6'd0, 0, 0);
    xf = 2'b10;
    for (int i = 0; i < 3; i++) push_st(13);
    play(6'b111111, 6'd0, 1'b0, seq.size());
    reset_check();
    build(6'b000000, 6'h3f, 0, 0);
    xf = 2'b10;
    for (int i = 0; i < 3; i++) push_st(13);
    play(6'b000000, 6'h3f, 1'b0, seq.size());
    reset_check();
`endif

    build(6'b001101, 6'd0, 0, 0);  play(6'b001101, 6'd0, 1'b0, seq.size());   // ori after reset

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore-style control FSM for the multicycle MIPS datapath. It replaces the single-cycle decoder when instruction and data share one memory port. It sequences each instruction through fetch, decode, execute, memory and write-back states, and stalls on a memory ready handshake. It adds a bounded wait-state timeout, and illegal-instruction trapping is available as a build option.

## Interface
- MAX_WAIT, 15: max consecutive cycles with mem_ready low in a wait state before timeout; 0 = unlimited.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- operation  in  6  IR[31:26], stable from DECODE until FETCH.
- func  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes current access this cycle.
- pc_we, ir_we, mem_we, reg_we  out  1  write enables.
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut.
- reg_write_addr  out  1  destination: 0 = rt, 1 = rd.
- reg_write_data  out  1  write-back source: 0 = ALUOut, 1 = memory data.
- alu_src_a  out  2  00 PC, 01 rs, 10 shamt.
- alu_src_b  out  2  00 rt, 01 const 4, 10 ext imm, 11 sign-ext imm<<2.
- imm_zero_ext  out  1  1 = zero-extend immediate (andi/ori).
- alu_controller  out  3  010 add, 110 sub, 000 and, 001 or, 011 sll, 100 srl, 101 sra, 111 slt.
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs.
- illegal, bus_err  out  1  sticky fault flags.
- state  out  4  current state, for debug.

## Operation
- States and codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, ALU_WB 7, BRANCH 8, IMM_EXEC 9, IMM_WB 10, JUMP 11, JR 12, HALT 13.
- Unlisted outputs are 0 in every state.
- FETCH: src_a 00, src_b 01, add, pc_src 00.
  - When mem_ready is high: ir_we = pc_we = 1, next state DECODE.
  - Otherwise the state holds.
- DECODE: src_a 00, src_b 11, add. Next state by operation:
  - 100011 or 101011 → MEM_ADDR.
  - 000000 → EXECUTE if func ∈ {sll 000000, srl 000010, sra 000011, sllv 000100, srlv 000110, srav 000111, add 100000, sub 100010, and 100100, or 100101, slt 101010}; func 001000 → JR.
  - 000100 or 000101 → BRANCH.
  - 001000, 001100 or 001101 → IMM_EXEC.
  - 000010 → JUMP.
- MEM_ADDR: src_a 01, src_b 10, add. Next MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: i_or_d 1; wait for mem_ready, then MEM_WB.
- MEM_WB: reg_we 1, addr 0, data 1. Next FETCH.
- MEM_WRITE: i_or_d 1, mem_we 1, held until mem_ready; then FETCH.
- EXECUTE: src_b 00; src_a 10 for sll/srl/sra, else 01. ALU code by func. Next ALU_WB.
- ALU_WB: reg_we 1, addr 1, data 0. Next FETCH.
- BRANCH: src_a 01, src_b 00, sub, pc_src 01. pc_we = zero (beq) or !zero (bne). Next FETCH.
- IMM_EXEC: src_a 01, src_b 10. addi: add, imm_zero_ext 0; andi: and, imm_zero_ext 1; ori: or, imm_zero_ext 1. Next IMM_WB.
- IMM_WB: reg_we 1, addr 0, data 0. Next FETCH.
- JUMP: pc_src 10, pc_we 1. Next FETCH.
- JR: pc_src 11, pc_we 1. Next FETCH.
- HALT: all enables 0; exits only on reset.
- Wait counter, width clog2(MAX_WAIT+1):
  - Cleared on entry to FETCH, MEM_READ or MEM_WRITE.
  - Increments each cycle in one of those states while mem_ready is low.
  - If MAX_WAIT > 0 and the counter reaches MAX_WAIT-1 with mem_ready low, next state HALT and bus_err is set.
  - mem_ready high on that cycle wins: normal advance, no error.

## Timing
- rst asserted, asynchronously: state = FETCH, counter = 0, illegal = bus_err = 0.
- While rst is high, every write enable is forced to 0. All other outputs take their FETCH values.
- Outputs are combinational from state. The only exceptions: pc_we/ir_we gated by mem_ready in FETCH, and pc_we by zero in BRANCH.
- Cycles per instruction with mem_ready always high: lw 5, sw 4, R-type 4, immediate 4, beq/bne 3, j 3, jr 3.
- Each low mem_ready cycle in a wait state adds exactly one cycle.
- Reset mid-instruction abandons it. No enable pulses after rst rises.

## Configuration
- MC_ILLEGAL_TRAP_EN defined:
  - An unknown opcode, or unknown R-type func, in DECODE → HALT, with illegal set and held until reset.
- MC_ILLEGAL_TRAP_EN undefined:
  - The same cases → FETCH with no write enables, i.e. executed as a 2-cycle NOP.
  - illegal is tied to 0.

## Test plan
- lw (operation 100011), mem_ready=1 → states 0,1,2,3,4,0; reg_we=1 only in MEM_WB, with reg_write_data=1 and reg_write_addr=0.
- beq with zero=1 vs zero=0 → pc_we=1 vs 0 in BRANCH, pc_src=01, alu_controller=110; 3 cycles each.
- sw with mem_ready low for 3 cycles in MEM_WRITE → mem_we high for 4 cycles, i_or_d=1, then FETCH; bus_err=0.
- MAX_WAIT=4, mem_ready stuck low in FETCH → HALT after 4 cycles, bus_err=1, all enables 0 until rst.
- sll (func 000000) → alu_src_a=10, alu_controller=011 in EXECUTE; ALU_WB with reg_write_addr=1.
- operation 111111 → with MC_ILLEGAL_TRAP_EN: HALT, illegal=1; without: back to FETCH in 2 cycles, illegal=0.
